// File: rtl/lp_esc_clock_recovery_rx_if.sv
// Signal bundle between the LP pad comparators / escape command decoder and the
// LP escape-mode receive front end.
interface lp_esc_clock_recovery_rx_if;
    logic       En;
    logic       A;
    logic       C;
    logic       RxClkEsc;
    logic       RxBit;
    logic       RxBitValid;
    logic [7:0] RxByte;
    logic       RxByteValid;
    logic       StopDet;
    logic       ProtoErr;
    logic       PartialErr;
    logic       TimeoutErr;

    modport master (
        output En, A, C,
        input  RxClkEsc, RxBit, RxBitValid, RxByte, RxByteValid,
               StopDet, ProtoErr, PartialErr, TimeoutErr
    );

    modport slave (
        input  En, A, C,
        output RxClkEsc, RxBit, RxBitValid, RxByte, RxByteValid,
               StopDet, ProtoErr, PartialErr, TimeoutErr
    );
endinterface

// File: rtl/lp_esc_clock_recovery_rx.sv
// LP escape-mode receive front end: synchronises and deglitches lines A/C, recovers the escape
// clock, decodes spaced-one-hot marks into LSB-first bytes and flags stop/protocol/timeout events.
module lp_esc_clock_recovery_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int TIMEOUT     = 255
) (
    input logic                       Clk,
    input logic                       Rst_n,
    lp_esc_clock_recovery_rx_if.slave lp
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STOP   = 3'd1,
        SPACE  = 3'd2,
        MARK_A = 3'd3,
        MARK_C = 3'd4
    } rxState_t;

    logic [1:0]             pin_s;
    logic [SYNC_STAGES-1:0] sync_r [2];
    logic [FW-1:0]          fltCnt_r [2];
    logic [1:0]             line_r;

    rxState_t state_r;
    rxState_t nextState_s;
    logic [1:0] markLine_s;

    logic       emit_s;
    logic       bitVal_s;
    logic       enterStop_s;
    logic       protoHit_s;

    logic [2:0]    bitCnt_r,      bitCntNxt_s;
    logic [7:0]    shift_r,       shiftNxt_s;
    logic [7:0]    rxByte_r,      rxByteNxt_s;
    logic          rxBit_r,       rxBitNxt_s;
    logic          rxBitValid_r,  rxBitValidNxt_s;
    logic          rxByteValid_r, rxByteValidNxt_s;
    logic          stopDet_r,     stopDetNxt_s;
    logic          protoErr_r,    protoErrNxt_s;
    logic          partialErr_r,  partialErrNxt_s;
    logic          timeoutErr_r,  timeoutErrNxt_s;
    logic [TW-1:0] toCnt_r,       toCntNxt_s;
    logic          rxClkEsc_r,    rxClkEscNxt_s;

    // Index 1 carries line A, index 0 line C, matching the {a_f, c_f} pair the FSM decodes.
    assign pin_s = {lp.A, lp.C};

    // Synchroniser chain and run-length deglitch filter for both LP lines.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 2; i++) begin
                sync_r[i]   <= {SYNC_STAGES{1'b1}};
                fltCnt_r[i] <= {FW{1'b0}};
            end
            line_r <= 2'b11;
        end else if (!lp.En) begin
            for (int i = 0; i < 2; i++) begin
                sync_r[i]   <= {SYNC_STAGES{1'b1}};
                fltCnt_r[i] <= {FW{1'b0}};
            end
            line_r <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], pin_s[i]};
                if (sync_r[i][SYNC_STAGES-1] == line_r[i]) begin
                    fltCnt_r[i] <= {FW{1'b0}};
                end else if (fltCnt_r[i] == FW'(FILTER_LEN - 1)) begin
                    fltCnt_r[i] <= {FW{1'b0}};
                    line_r[i]   <= sync_r[i][SYNC_STAGES-1];
                end else begin
                    fltCnt_r[i] <= fltCnt_r[i] + FW'(1);
                end
            end
        end
    end

    // Line pair that keeps the current mark state alive; anything else is a transition.
    assign markLine_s = (state_r == MARK_A) ? 2'b10 : 2'b01;

    // Next-state decode on the filtered line pair; raises the bit/stop/protocol event flags.
    always_comb begin
        nextState_s = state_r;
        emit_s      = 1'b0;
        bitVal_s    = 1'b0;
        enterStop_s = 1'b0;
        protoHit_s  = 1'b0;
        if (!lp.En) begin
            nextState_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    nextState_s = STOP;
                    enterStop_s = 1'b1;
                end
                STOP: begin
                    if (line_r == 2'b00) begin
                        nextState_s = SPACE;
                    end else begin
                        nextState_s = STOP;
                    end
                end
                SPACE: begin
                    case (line_r)
                        2'b10:   nextState_s = MARK_A;
                        2'b01:   nextState_s = MARK_C;
                        2'b11: begin
                            nextState_s = STOP;
                            enterStop_s = 1'b1;
                        end
                        default: nextState_s = SPACE;
                    endcase
                end
                MARK_A, MARK_C: begin
                    if (line_r == 2'b00) begin
                        nextState_s = SPACE;
                        emit_s      = 1'b1;
                        bitVal_s    = (state_r == MARK_A);
                    end else if (line_r == 2'b11) begin
                        nextState_s = STOP;
                        enterStop_s = 1'b1;
                    end else if (line_r == markLine_s) begin
                        nextState_s = state_r;
                    end else begin
                        // Jumping straight to the other mark skips the space: protocol error.
                        protoHit_s  = 1'b1;
                        nextState_s = (line_r == 2'b10) ? MARK_A : MARK_C;
                    end
                end
                default: nextState_s = IDLE;
            endcase
        end
    end

    // Byte assembly, event strobes, space timeout and recovered clock for the next cycle.
    always_comb begin
        bitCntNxt_s      = bitCnt_r;
        shiftNxt_s       = shift_r;
        rxByteNxt_s      = rxByte_r;
        rxBitNxt_s       = rxBit_r;
        rxBitValidNxt_s  = 1'b0;
        rxByteValidNxt_s = 1'b0;
        stopDetNxt_s     = 1'b0;
        protoErrNxt_s    = 1'b0;
        partialErrNxt_s  = 1'b0;
        timeoutErrNxt_s  = timeoutErr_r;
        toCntNxt_s       = toCnt_r;
        rxClkEscNxt_s    = 1'b0;
        if (!lp.En) begin
            bitCntNxt_s     = 3'd0;
            shiftNxt_s      = 8'h00;
            rxByteNxt_s     = 8'h00;
            rxBitNxt_s      = 1'b0;
            timeoutErrNxt_s = 1'b0;
            toCntNxt_s      = {TW{1'b0}};
        end else begin
            if (protoHit_s) begin
                bitCntNxt_s   = 3'd0;
                shiftNxt_s    = 8'h00;
                protoErrNxt_s = 1'b1;
            end else if (emit_s) begin
                shiftNxt_s[bitCnt_r] = bitVal_s;
                rxBitNxt_s           = bitVal_s;
                rxBitValidNxt_s      = 1'b1;
                bitCntNxt_s          = bitCnt_r + 3'd1;
                if (bitCnt_r == 3'd7) begin
                    rxByteNxt_s      = shiftNxt_s;
                    rxByteValidNxt_s = 1'b1;
                end else begin
                    rxByteNxt_s      = rxByte_r;
                end
            end else if (enterStop_s) begin
                stopDetNxt_s    = 1'b1;
                partialErrNxt_s = (bitCnt_r != 3'd0);
                bitCntNxt_s     = 3'd0;
                shiftNxt_s      = 8'h00;
            end else begin
                bitCntNxt_s = bitCnt_r;
            end

            if (state_r == SPACE) begin
                if (toCnt_r != TW'(TIMEOUT)) begin
                    toCntNxt_s = toCnt_r + TW'(1);
                end else begin
                    toCntNxt_s = toCnt_r;
                end
                if (toCnt_r == TW'(TIMEOUT - 1)) begin
                    timeoutErrNxt_s = 1'b1;
                end else begin
                    timeoutErrNxt_s = timeoutErr_r;
                end
            end else begin
                toCntNxt_s = {TW{1'b0}};
            end

            // En low is the only path into IDLE, and that branch already holds the clock at 0.
            rxClkEscNxt_s = line_r[1] ^ line_r[0];
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r       <= IDLE;
            bitCnt_r      <= 3'd0;
            shift_r       <= 8'h00;
            rxByte_r      <= 8'h00;
            rxBit_r       <= 1'b0;
            rxBitValid_r  <= 1'b0;
            rxByteValid_r <= 1'b0;
            stopDet_r     <= 1'b0;
            protoErr_r    <= 1'b0;
            partialErr_r  <= 1'b0;
            timeoutErr_r  <= 1'b0;
            toCnt_r       <= {TW{1'b0}};
            rxClkEsc_r    <= 1'b0;
        end else begin
            state_r       <= nextState_s;
            bitCnt_r      <= bitCntNxt_s;
            shift_r       <= shiftNxt_s;
            rxByte_r      <= rxByteNxt_s;
            rxBit_r       <= rxBitNxt_s;
            rxBitValid_r  <= rxBitValidNxt_s;
            rxByteValid_r <= rxByteValidNxt_s;
            stopDet_r     <= stopDetNxt_s;
            protoErr_r    <= protoErrNxt_s;
            partialErr_r  <= partialErrNxt_s;
            timeoutErr_r  <= timeoutErrNxt_s;
            toCnt_r       <= toCntNxt_s;
            rxClkEsc_r    <= rxClkEscNxt_s;
        end
    end

    assign lp.RxClkEsc    = rxClkEsc_r;
    assign lp.RxBit       = rxBit_r;
    assign lp.RxBitValid  = rxBitValid_r;
    assign lp.RxByte      = rxByte_r;
    assign lp.RxByteValid = rxByteValid_r;
    assign lp.StopDet     = stopDet_r;
    assign lp.ProtoErr    = protoErr_r;
    assign lp.PartialErr  = partialErr_r;
    assign lp.TimeoutErr  = timeoutErr_r;

endmodule

// File: tb/tb_lp_esc_clock_recovery_rx.sv
// Bench for lp_esc_clock_recovery_rx: directed scenarios plus random line activity, all outputs
// compared every cycle against a behavioural model of the escape-mode receive rules.
module tb_lp_esc_clock_recovery_rx;

    localparam int S = 2;
    localparam int F = 3;
    localparam int T = 255;
    localparam int L = S + F;

    logic Clk;
    logic Rst_n;
    lp_esc_clock_recovery_rx_if bus();

    lp_esc_clock_recovery_rx #(.SYNC_STAGES(S), .FILTER_LEN(F), .TIMEOUT(T)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .lp    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pin history windows, accepted line phase, collected bits, space run length.
    bit       histA[$];
    bit       histC[$];
    bit [1:0] mLine;
    bit [1:0] mPh;
    bit       mActive;
    bit       mBits[$];
    int       mSpaceRun;
    bit       eClk, eBit, eBitV, eByteV, eStop, eProto, ePart, eTo;
    bit [7:0] eByte;

    task automatic modelClear();
        mActive   = 1'b0;
        mPh       = 2'b11;
        mLine     = 2'b11;
        mSpaceRun = 0;
        mBits.delete();
        histA.delete();
        histC.delete();
        for (int i = 0; i < L; i++) begin
            histA.push_back(1'b1);
            histC.push_back(1'b1);
        end
        {eClk, eBit, eBitV, eByteV, eStop, eProto, ePart, eTo} = 8'h00;
        eByte = 8'h00;
    endtask

    function automatic bit isMark(input bit [1:0] p);
        return p[1] ^ p[0];
    endfunction

    function automatic bit accepts(input bit [1:0] ph, input bit [1:0] p);
        if (ph == 2'b11) return p == 2'b00;
        if (ph == 2'b00) return p != 2'b00;
        return p != ph;
    endfunction

    // A filtered line flips once the last F synchronised samples all disagree with it.
    function automatic bit flips(input bit h[$], input bit cur);
        for (int i = 1; i <= F; i++) if (h[i] == cur) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelStep(input bit en, input bit pa, input bit pc);
        bit [1:0] p;
        if (!en) begin
            modelClear();
            return;
        end
        p = mLine;
        {eBitV, eByteV, eStop, eProto, ePart} = 5'b00000;
        if (mActive && mPh == 2'b00) mSpaceRun++;
        else mSpaceRun = 0;
        if (mSpaceRun >= T) eTo = 1'b1;
        if (!mActive) begin
            mActive = 1'b1;
            mPh     = 2'b11;
            eStop   = 1'b1;
        end else if (accepts(mPh, p)) begin
            if (p == 2'b11) begin
                eStop = 1'b1;
                ePart = (mBits.size() != 0);
                mBits.delete();
            end else if (isMark(mPh) && p == 2'b00) begin
                eBitV = 1'b1;
                eBit  = mPh[1];
                mBits.push_back(mPh[1]);
                if (mBits.size() == 8) begin
                    for (int i = 0; i < 8; i++) eByte[i] = mBits[i];
                    eByteV = 1'b1;
                    mBits.delete();
                end
            end else if (isMark(mPh) && isMark(p)) begin
                eProto = 1'b1;
                mBits.delete();
            end
            mPh = p;
        end
        eClk = p[1] ^ p[0];
        if (flips(histA, mLine[1])) mLine[1] = ~mLine[1];
        if (flips(histC, mLine[0])) mLine[0] = ~mLine[0];
        histA.push_back(pa);
        histC.push_back(pc);
        void'(histA.pop_front());
        void'(histC.pop_front());
    endtask

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) modelClear();
        else modelStep(bus.En, bus.A, bus.C);
    end

    // Per-cycle comparison and strobe bookkeeping for the directed checks.
    int       nBitV = 0, nByteV = 0, nStop = 0, nProto = 0, nPart = 0, nClkE = 0;
    bit       lastBit;
    bit [7:0] lastByte;
    logic     prevClk = 1'b0;

    always @(negedge Clk) begin
        if (Rst_n !== 1'bx) begin
            chk("RxClkEsc",    32'(bus.RxClkEsc),    32'(eClk));
            chk("RxBit",       32'(bus.RxBit),       32'(eBit));
            chk("RxBitValid",  32'(bus.RxBitValid),  32'(eBitV));
            chk("RxByte",      32'(bus.RxByte),      32'(eByte));
            chk("RxByteValid", 32'(bus.RxByteValid), 32'(eByteV));
            chk("StopDet",     32'(bus.StopDet),     32'(eStop));
            chk("ProtoErr",    32'(bus.ProtoErr),    32'(eProto));
            chk("PartialErr",  32'(bus.PartialErr),  32'(ePart));
            chk("TimeoutErr",  32'(bus.TimeoutErr),  32'(eTo));
            if (bus.RxBitValid === 1'b1) begin
                nBitV++;
                lastBit = bus.RxBit;
            end
            if (bus.RxByteValid === 1'b1) begin
                nByteV++;
                lastByte = bus.RxByte;
            end
            if (bus.StopDet === 1'b1) nStop++;
            if (bus.ProtoErr === 1'b1) nProto++;
            if (bus.PartialErr === 1'b1) nPart++;
            if (bus.RxClkEsc !== prevClk) nClkE++;
            prevClk = bus.RxClkEsc;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic drive(input bit a, input bit c, input int n);
        bus.A = a;
        bus.C = c;
        step(n);
    endtask

    task automatic sendBits(input bit [7:0] v, input int first, input int len);
        for (int i = first; i < 8; i++) begin
            drive(v[i], ~v[i], len);
            drive(1'b0, 1'b0, len);
        end
    endtask

    int bBit, bByte, bStop, bProto, bPart, bClk;

    task automatic snap();
        bBit = nBitV; bByte = nByteV; bStop = nStop;
        bProto = nProto; bPart = nPart; bClk = nClkE;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.En = 1'b1;
        bus.A  = 1'b1;
        bus.C  = 1'b1;
        Rst_n  = 1'b1;
        #1 Rst_n = 1'b0;
        step(3);
        chk("rst_byte", 32'(bus.RxByte), 32'h0);
        chk("rst_stop", 32'(bus.StopDet), 32'h0);
        chk("rst_clk",  32'(bus.RxClkEsc), 32'h0);

        // 1: leave reset in LP-11
        Rst_n = 1'b1;
        snap();
        step(12);
        chk("tc1_stop_once", 32'(nStop - bStop), 32'd1);
        chk("tc1_clk_quiet", 32'(nClkE - bClk), 32'd0);

        // 2: A,C,A,A,C,C,C,A -> 8'h8D
        snap();
        drive(1'b0, 1'b0, 8);
        sendBits(8'h8D, 0, 8);
        step(4);
        chk("tc2_bits",     32'(nBitV - bBit), 32'd8);
        chk("tc2_bytes",    32'(nByteV - bByte), 32'd1);
        chk("tc2_byte_val", 32'(lastByte), 32'h8D);
        chk("tc2_byte_out", 32'(bus.RxByte), 32'h8D);
        chk("tc2_clk_edges", 32'(nClkE - bClk), 32'd16);

        // 3: short glitch rejected, full-length glitch becomes a mark
        snap();
        drive(1'b1, 1'b0, 2);
        drive(1'b0, 1'b0, 10);
        chk("tc3_glitch_bits",  32'(nBitV - bBit), 32'd0);
        chk("tc3_glitch_clk",   32'(nClkE - bClk), 32'd0);
        chk("tc3_glitch_proto", 32'(nProto - bProto), 32'd0);
        snap();
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 10);
        chk("tc3_mark_bits", 32'(nBitV - bBit), 32'd1);
        chk("tc3_mark_val",  32'(lastBit), 32'd1);

        // 4: mark A straight to mark C, C mark then starts byte 8'h5A
        snap();
        drive(1'b1, 1'b0, 8);
        drive(1'b0, 1'b1, 8);
        drive(1'b0, 1'b0, 8);
        chk("tc4_proto", 32'(nProto - bProto), 32'd1);
        sendBits(8'h5A, 1, 8);
        step(4);
        chk("tc4_bytes",    32'(nByteV - bByte), 32'd1);
        chk("tc4_byte_val", 32'(lastByte), 32'h5A);

        // 5: three bits then stop
        snap();
        sendBits(8'h03, 5, 8);
        drive(1'b1, 1'b1, 10);
        chk("tc5_stop",    32'(nStop - bStop), 32'd1);
        chk("tc5_partial", 32'(nPart - bPart), 32'd1);
        chk("tc5_nobyte",  32'(nByteV - bByte), 32'd0);
        snap();
        drive(1'b0, 1'b0, 8);
        sendBits(8'hC3, 0, 8);
        drive(1'b1, 1'b1, 10);
        chk("tc5_byte_val",   32'(lastByte), 32'hC3);
        chk("tc5_bytes",      32'(nByteV - bByte), 32'd1);
        chk("tc5_no_partial", 32'(nPart - bPart), 32'd0);

        // 6: long space -> sticky timeout, cleared by En low
        drive(1'b0, 1'b0, 250);
        chk("tc6_not_yet", 32'(bus.TimeoutErr), 32'd0);
        drive(1'b0, 1'b0, 50);
        chk("tc6_set", 32'(bus.TimeoutErr), 32'd1);
        sendBits(8'h8D, 0, 8);
        chk("tc6_sticky", 32'(bus.TimeoutErr), 32'd1);
        bus.A  = 1'b1;
        bus.C  = 1'b1;
        bus.En = 1'b0;
        step(3);
        chk("tc6_cleared", 32'(bus.TimeoutErr), 32'd0);
        chk("tc6_byte_clr", 32'(bus.RxByte), 32'h0);
        bus.En = 1'b1;
        step(12);

        // Random line activity, checked cycle by cycle against the model.
        for (int ep = 0; ep < 60; ep++) begin
            case ($urandom_range(6, 0))
                0, 1: begin
                    drive(1'b0, 1'b0, $urandom_range(8, 3));
                    sendBits(8'($urandom_range(255, 0)), $urandom_range(7, 0), $urandom_range(9, 3));
                end
                2: begin
                    drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom_range(4, 1));
                    drive(1'b0, 1'b0, $urandom_range(8, 3));
                end
                3: begin
                    drive(1'b1, 1'b0, $urandom_range(8, 3));
                    drive(1'b0, 1'b1, $urandom_range(8, 3));
                    drive(1'b0, 1'b0, $urandom_range(8, 3));
                end
                4: begin
                    drive(1'b1, 1'b1, $urandom_range(10, 1));
                    drive(1'b0, 1'b0, $urandom_range(10, 3));
                end
                5: begin
                    repeat (10) drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                                      $urandom_range(3, 1));
                end
                default: begin
                    bus.En = 1'b0;
                    drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom_range(5, 1));
                    bus.En = 1'b1;
                    drive(1'b1, 1'b1, $urandom_range(10, 1));
                end
            endcase
        end
        step(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
